// File: rtl/spcpu_fetch_unit_pkg.sv
// Shared types and constants for the spcpu instruction-fetch front end.
// Imported by the fetch unit, its halfword queue and the bench.
package spcpu_fetch_unit_pkg;

  typedef enum logic {
    cpu_data_acc_sz_8  = 1'b0,
    cpu_data_acc_sz_16 = 1'b1
  } cpu_data_acc_sz_t;

  localparam int FETCH_HW_WIDTH     = 16;
  localparam int INSTR_16_NUM_BYTES = 2;
  localparam int INSTR_32_NUM_BYTES = 4;
  localparam int FQ_COUNT_WIDTH     = 8;

  typedef logic [FETCH_HW_WIDTH-1:0] halfword_t;
  typedef logic [FQ_COUNT_WIDTH-1:0] fq_count_t;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_BUSY,
    FS_DISCARD
  } fetch_state_t;

  function automatic logic is_long(
    input halfword_t hw,
    input halfword_t mask,
    input halfword_t match
  );
    return (hw & mask) == match;
  endfunction

endpackage

// File: rtl/spcpu_fetch_unit_if.sv
// Memory-read and decoder-side signals of the fetch unit.
// master = fetch unit, slave = memory/decoder/redirect source.
interface spcpu_fetch_unit_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_acc_sz;
  logic                  mem_ack;
  logic [15:0]           mem_rdata;

  logic                  instr_valid;
  logic [15:0]           instr_hi;
  logic [15:0]           instr_lo;
  logic                  instr_is_32;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_ready;

  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_acc_sz,
    input  mem_ack,
    input  mem_rdata,
    output instr_valid,
    output instr_hi,
    output instr_lo,
    output instr_is_32,
    output instr_pc,
    input  instr_ready,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_acc_sz,
    output mem_ack,
    output mem_rdata,
    input  instr_valid,
    input  instr_hi,
    input  instr_lo,
    input  instr_is_32,
    input  instr_pc,
    output instr_ready,
    output redirect_valid,
    output redirect_pc
  );

endinterface

// File: rtl/spcpu_halfword_queue.sv
// Circular halfword buffer: push 1, pop 0..2, flush, two-entry peek.
// DEPTH must be a power of two so the pointers wrap naturally.
module spcpu_halfword_queue
  import spcpu_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  input  logic      push,
  input  halfword_t push_data,
  input  logic [1:0] pop,
  output halfword_t peek0,
  output halfword_t peek1,
  output fq_count_t count
);

  localparam int PTR_W = $clog2(DEPTH);

  halfword_t        slots [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_nx1;

  assign head_nx1 = head + PTR_W'(1);
  assign peek0    = slots[head];
  assign peek1    = slots[head_nx1];

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      slots[tail] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      head  <= head + PTR_W'(pop);
      count <= count + fq_count_t'(push) - fq_count_t'(pop);
    end
  end

endmodule

// File: rtl/spcpu_fetch_unit.sv
// spcpu fetch front end: halfword prefetch, 16/32-bit instruction
// assembly, and redirect handling with in-flight response discard.
module spcpu_fetch_unit
  import spcpu_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter halfword_t             LONG_MASK   = 16'hf000,
  parameter halfword_t             LONG_MATCH  = 16'hf000
) (
  input logic                clk,
  input logic                reset,
  spcpu_fetch_unit_if.master bus
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  fetch_state_t state;
  logic         req;
  addr_t        req_addr;
  addr_t        fetch_pc;
  addr_t        head_pc;
  fq_count_t    count;
  fq_count_t    count_next;
  halfword_t    hw0;
  halfword_t    hw1;
  logic         head_long;
  logic         valid;
  logic         fire;
  logic         ack;
  logic         push;
  logic         redirect;
  logic [1:0]   pop;
  addr_t        redirect_addr;
  addr_t        fetch_pc_next;
  addr_t        head_pc_next;
  logic         has_room;

  assign redirect      = bus.redirect_valid;
  assign redirect_addr = bus.redirect_pc & ~addr_t'(1);
  assign ack           = req & bus.mem_ack;
  // Responses to a request issued before a redirect never enter the queue.
  assign push          = ack & (state != FS_DISCARD) & ~redirect;

  assign head_long = is_long(hw0, LONG_MASK, LONG_MATCH);
  assign valid     = head_long ? (count >= fq_count_t'(2))
                               : (count >= fq_count_t'(1));
  assign fire      = valid & bus.instr_ready;

  always_comb begin
    pop = 2'd0;
    if (fire && !redirect) begin
      pop = head_long ? 2'd2 : 2'd1;
    end
  end

  assign count_next = redirect ? '0
                    : count + fq_count_t'(push) - fq_count_t'(pop);
  assign has_room   = count_next < fq_count_t'(QUEUE_DEPTH);

  always_comb begin
    fetch_pc_next = fetch_pc;
    head_pc_next  = head_pc;
    if (redirect) begin
      fetch_pc_next = redirect_addr;
      head_pc_next  = redirect_addr;
    end else begin
      if (push) begin
        fetch_pc_next = fetch_pc + addr_t'(INSTR_16_NUM_BYTES);
      end
      if (fire) begin
        head_pc_next = head_long
                     ? head_pc + addr_t'(INSTR_32_NUM_BYTES)
                     : head_pc + addr_t'(INSTR_16_NUM_BYTES);
      end
    end
  end

  spcpu_halfword_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (bus.mem_rdata),
    .pop       (pop),
    .peek0     (hw0),
    .peek1     (hw1),
    .count     (count)
  );

  // A pending request is never withdrawn; it only changes on ack or idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FS_IDLE;
      req      <= 1'b0;
      req_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
    end else begin
      fetch_pc <= fetch_pc_next;
      head_pc  <= head_pc_next;
      if (req && !bus.mem_ack) begin
        if (redirect) begin
          state <= FS_DISCARD;
        end
      end else begin
        req      <= has_room;
        req_addr <= fetch_pc_next;
        state    <= has_room ? FS_BUSY : FS_IDLE;
      end
    end
  end

  assign bus.mem_req     = req;
  assign bus.mem_addr    = req_addr;
  assign bus.mem_acc_sz  = cpu_data_acc_sz_16;
  assign bus.instr_valid = valid;
  assign bus.instr_hi    = hw0;
  assign bus.instr_lo    = head_long ? hw1 : '0;
  assign bus.instr_is_32 = head_long;
  assign bus.instr_pc    = head_pc;

endmodule

// File: tb/tb_spcpu_fetch_unit.sv
// Directed bench for spcpu_fetch_unit with a scoreboard of expected
// instructions checked by a monitor on each decoder handshake.
module tb_spcpu_fetch_unit;
  import spcpu_fetch_unit_pkg::*;

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        is32;
    logic [15:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spcpu_fetch_unit_if #(.ADDR_WIDTH(16)) bus ();

  spcpu_fetch_unit #(
    .ADDR_WIDTH  (16),
    .QUEUE_DEPTH (4),
    .RESET_PC    (16'h0000),
    .LONG_MASK   (16'hf000),
    .LONG_MATCH  (16'hf000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem_img [32768];
  logic ack_auto = 1'b0;
  logic ack_force = 1'b0;

  assign bus.mem_ack   = ack_auto | ack_force;
  assign bus.mem_rdata = mem_img[bus.mem_addr[15:1]];

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t mon_g;
  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;

  always @(posedge clk) begin
    if (reset) ack_cnt <= 0;
    else if (bus.mem_req && bus.mem_ack) ack_cnt <= ack_cnt + 1;
  end

  always @(negedge clk) begin
    if (!reset && bus.instr_valid && bus.instr_ready) begin
      mon_g = '{bus.instr_hi, bus.instr_lo,
                bus.instr_is_32, bus.instr_pc};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL instr_unexpected got hi=%h lo=%h is32=%b pc=%h",
                 mon_g.hi, mon_g.lo, mon_g.is32, mon_g.pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_g !== mon_e) begin
          errors++;
          $display("FAIL instr got hi=%h lo=%h is32=%b pc=%h want hi=%h lo=%h is32=%b pc=%h",
                   mon_g.hi, mon_g.lo, mon_g.is32, mon_g.pc,
                   mon_e.hi, mon_e.lo, mon_e.is32, mon_e.pc);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic expect_instr(input logic [15:0] hi,
                              input logic [15:0] lo,
                              input logic        is32,
                              input logic [15:0] pc);
    exp_t e;
    e = '{hi, lo, is32, pc};
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    bus.instr_ready = 1'b1;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    bus.instr_ready = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout pending=%0d", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    bus.redirect_pc    = pc;
    bus.redirect_valid = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic reset_hold();
    bus.instr_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem_img[i] = 16'h0000;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;

    // basic 16-bit fetch and reset state
    mem_img[0] = 16'h1234;
    mem_img[1] = 16'h5678;
    ack_auto = 1'b1;
    reset_hold();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_pc", bus.instr_pc, 0);
    chk("acc_sz", bus.mem_acc_sz, 1);
    reset = 1'b0;
    tick();
    chk("rel_req", bus.mem_req, 1);
    chk("rel_addr", bus.mem_addr, 16'h0000);
    chk("rel_valid", bus.instr_valid, 0);
    tick();
    chk("short_valid_n1", bus.instr_valid, 1);
    chk("addr_n1", bus.mem_addr, 16'h0002);
    expect_instr(16'h1234, 16'h0000, 1'b0, 16'h0000);
    expect_instr(16'h5678, 16'h0000, 1'b0, 16'h0002);
    drain("t1");

    // 32-bit instruction
    mem_img[0] = 16'hf001;
    mem_img[1] = 16'habcd;
    mem_img[2] = 16'h0007;
    reset_hold();
    reset = 1'b0;
    tick();
    tick();
    chk("long_wait_n1", bus.instr_valid, 0);
    tick();
    chk("long_valid_n2", bus.instr_valid, 1);
    chk("long_is32", bus.instr_is_32, 1);
    expect_instr(16'hf001, 16'habcd, 1'b1, 16'h0000);
    expect_instr(16'h0007, 16'h0000, 1'b0, 16'h0004);
    drain("t2");

    // backpressure: queue fills to four, one pop frees a slot
    mem_img[0] = 16'h0000;
    mem_img[1] = 16'h0000;
    mem_img[2] = 16'h0000;
    reset_hold();
    reset = 1'b0;
    tick();
    repeat (10) tick();
    chk("full_acks", ack_cnt, 4);
    chk("full_req", bus.mem_req, 0);
    chk("full_valid", bus.instr_valid, 1);
    expect_instr(16'h0000, 16'h0000, 1'b0, 16'h0000);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("refill_req", bus.mem_req, 1);
    chk("refill_addr", bus.mem_addr, 16'h0008);
    repeat (6) tick();
    chk("refill_acks", ack_cnt, 5);
    chk("refill_req_off", bus.mem_req, 0);
    chk("refill_drained", exp_q.size(), 0);

    // redirect with a pending request: late data dropped
    mem_img[0]    = 16'h1111;
    mem_img[16'h80] = 16'h2222;
    mem_img[16'h81] = 16'h3333;
    ack_auto = 1'b0;
    ack_force = 1'b0;
    reset_hold();
    reset = 1'b0;
    tick();
    chk("pend_req", bus.mem_req, 1);
    do_redirect(16'h0101);
    chk("pend_hold_req", bus.mem_req, 1);
    chk("pend_hold_addr", bus.mem_addr, 16'h0000);
    chk("pend_valid", bus.instr_valid, 0);
    tick();
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    chk("post_drop_req", bus.mem_req, 1);
    chk("post_drop_addr", bus.mem_addr, 16'h0100);
    chk("post_drop_valid", bus.instr_valid, 0);
    ack_auto = 1'b1;
    expect_instr(16'h2222, 16'h0000, 1'b0, 16'h0100);
    expect_instr(16'h3333, 16'h0000, 1'b0, 16'h0102);
    drain("t4");

    // 32-bit instruction spanning the address wrap
    mem_img[16'h7fff] = 16'hf000;
    mem_img[0] = 16'h0042;
    mem_img[1] = 16'h0055;
    do_redirect(16'hfffe);
    chk("wrap_valid0", bus.instr_valid, 0);
    chk("wrap_addr", bus.mem_addr, 16'hfffe);
    expect_instr(16'hf000, 16'h0042, 1'b1, 16'hfffe);
    expect_instr(16'h0055, 16'h0000, 1'b0, 16'h0002);
    drain("t5");

    // reset mid-transaction
    mem_img[0] = 16'h4444;
    mem_img[1] = 16'h5555;
    mem_img[2] = 16'h6666;
    ack_auto = 1'b0;
    reset_hold();
    reset = 1'b0;
    tick();
    ack_force = 1'b1;
    repeat (3) tick();
    ack_force = 1'b0;
    chk("mid_valid", bus.instr_valid, 1);
    chk("mid_req", bus.mem_req, 1);
    chk("mid_addr", bus.mem_addr, 16'h0006);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", bus.instr_valid, 0);
    chk("mid_rst_req", bus.mem_req, 0);
    chk("mid_rst_addr", bus.mem_addr, 16'h0000);
    chk("mid_rst_pc", bus.instr_pc, 16'h0000);
    reset = 1'b0;
    ack_auto = 1'b1;
    tick();
    chk("restart_req", bus.mem_req, 1);
    chk("restart_addr", bus.mem_addr, 16'h0000);
    expect_instr(16'h4444, 16'h0000, 1'b0, 16'h0000);
    expect_instr(16'h5555, 16'h0000, 1'b0, 16'h0002);
    drain("t6");

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
